// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: architectural register file with per-register pending-write counters for RAW hazard detection.
// Optional RF_WB_BYPASS_EN forwards the same-cycle writeback value and post-decrement busy to the read ports.
module regfile_scoreboard #(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 16,
    parameter int ADDR_W     = 4,
    parameter int PEND_W     = 2,
    parameter int INIT_INDEX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy2,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic              issue_full,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_err,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam logic [ADDR_W:0]   NR   = (ADDR_W+1)'(NUM_REGS);
    localparam logic [PEND_W-1:0] CMAX = '1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [PEND_W-1:0] cnt_q  [NUM_REGS];
    logic [PEND_W-1:0] cnt_d  [NUM_REGS];
    logic [NUM_REGS-1:0] inc, dec;
    logic wb_ok, wb_err_q, wb_err_d;

    function automatic logic in_rng(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < NR;
    endfunction

    // Out-of-range indices behave as an idle register: count 0, data 0.
    function automatic logic [PEND_W-1:0] cnt_at(input logic [ADDR_W-1:0] a);
        return in_rng(a) ? cnt_q[a] : '0;
    endfunction

    function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
`ifdef RF_WB_BYPASS_EN
        if (wb_ok && wb_dest == a) return wb_data;
`endif
        return in_rng(a) ? regs_q[a] : '0;
    endfunction

    function automatic logic rd_bsy(input logic [ADDR_W-1:0] a);
`ifdef RF_WB_BYPASS_EN
        if (wb_ok && wb_dest == a) return cnt_at(a) > PEND_W'(1);
`endif
        return cnt_at(a) != '0;
    endfunction

    always_comb begin
        wb_ok      = wb_en && in_rng(wb_dest);
        issue_full = cnt_at(issue_dest) == CMAX;
        wb_err_d   = wb_ok && cnt_at(wb_dest) == '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i]   = issue_en && !issue_full && issue_dest == ADDR_W'(i);
            dec[i]   = wb_ok && wb_dest == ADDR_W'(i) && cnt_q[i] != '0;
            cnt_d[i] = (inc[i] && !dec[i]) ? cnt_q[i] + 1'b1 :
                       (dec[i] && !inc[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
        end
    end

    always_comb begin
        rd_data1 = rd_val(rd_addr1);
        rd_busy1 = rd_bsy(rd_addr1);
        rd_data2 = rd_val(rd_addr2);
        rd_busy2 = rd_bsy(rd_addr2);
        dbg_data = in_rng(dbg_addr) ? regs_q[dbg_addr] : '0;
        wb_err   = wb_err_q;
    end

    // The top register is the PC and always resets to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (INIT_INDEX != 0 && i != NUM_REGS-1) ? DATA_W'(i) : '0;
                cnt_q[i]  <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            if (wb_ok) regs_q[wb_dest] <= wb_data;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vector table plus model-driven random traffic for regfile_scoreboard.
module tb_regfile_scoreboard;
`ifdef RF_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [3:0]  a1, a2, id, wd;
        logic        ie, we;
        logic [31:0] wdat;
    } in_t;
    typedef struct {
        logic [31:0] d1, d2;
        logic        b1, b2, full, err;
    } exp_t;
    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  rd_addr1 = '0, rd_addr2 = '0, issue_dest = '0, wb_dest = '0, dbg_addr = '0;
    logic [31:0] rd_data1, rd_data2, wb_data = '0, dbg_data;
    logic        rd_busy1, rd_busy2, issue_en = 1'b0, issue_full, wb_en = 1'b0, wb_err;
    int          checks = 0, errors = 0;
    exp_t        sbq[$];
    vec_t        tbl[24];
    logic [31:0] m_reg[16];
    int          m_cnt[16];
    bit          m_err;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
        .issue_en(issue_en), .issue_dest(issue_dest), .issue_full(issue_full),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .wb_err(wb_err),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int a1, int a2, int ie, int id, int we, int wd, int wdat,
                                int d1, int b1, int d2, int b2, int full, int err);
        vec_t v;
        v.i.a1 = 4'(a1); v.i.a2 = 4'(a2); v.i.ie = 1'(ie); v.i.id = 4'(id);
        v.i.we = 1'(we); v.i.wd = 4'(wd); v.i.wdat = 32'(wdat);
        v.e.d1 = 32'(d1); v.e.b1 = 1'(b1); v.e.d2 = 32'(d2); v.e.b2 = 1'(b2);
        v.e.full = 1'(full); v.e.err = 1'(err);
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare at the falling edge.
    task automatic run(input in_t i, input exp_t e);
        exp_t x;
        rd_addr1 = i.a1; rd_addr2 = i.a2; issue_en = i.ie; issue_dest = i.id;
        wb_en = i.we; wb_dest = i.wd; wb_data = i.wdat; dbg_addr = i.a1;
        sbq.push_back(e);
        @(negedge clk);
        if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: empty queue at %0t", $time);
        end else begin
            x = sbq.pop_front();
            chk("rd_data1", rd_data1, x.d1);
            chk("rd_busy1", 32'(rd_busy1), 32'(x.b1));
            chk("rd_data2", rd_data2, x.d2);
            chk("rd_busy2", 32'(rd_busy2), 32'(x.b2));
            chk("issue_full", 32'(issue_full), 32'(x.full));
            chk("wb_err", 32'(wb_err), 32'(x.err));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        in_t  ri;
        exp_t re;
        bit   full, hit1, hit2;
        tbl[0]  = mk(5, 15, 0, 0, 0, 0, 0,          5, 0, 0, 0, 0, 0);
        tbl[1]  = mk(3, 3, 1, 3, 0, 0, 0,           3, 0, 3, 0, 0, 0);
        tbl[2]  = mk(3, 3, 0, 3, 0, 0, 0,           3, 1, 3, 1, 0, 0);
        tbl[3]  = mk(3, 4, 0, 3, 1, 3, 'hDEAD,      BYP ? 'hDEAD : 3, !BYP, 4, 0, 0, 0);
        tbl[4]  = mk(3, 3, 0, 0, 0, 0, 0,           'hDEAD, 0, 'hDEAD, 0, 0, 0);
        tbl[5]  = mk(7, 7, 1, 7, 0, 0, 0,           7, 0, 7, 0, 0, 0);
        tbl[6]  = mk(7, 7, 1, 7, 0, 0, 0,           7, 1, 7, 1, 0, 0);
        tbl[7]  = mk(7, 7, 1, 7, 0, 0, 0,           7, 1, 7, 1, 0, 0);
        tbl[8]  = mk(7, 7, 1, 7, 0, 0, 0,           7, 1, 7, 1, 1, 0);
        tbl[9]  = mk(7, 0, 0, 7, 1, 7, 'h70,        BYP ? 'h70 : 7, 1, 0, 0, 1, 0);
        tbl[10] = mk(7, 0, 0, 7, 1, 7, 'h71,        BYP ? 'h71 : 'h70, 1, 0, 0, 0, 0);
        tbl[11] = mk(7, 0, 0, 7, 1, 7, 'h72,        BYP ? 'h72 : 'h71, !BYP, 0, 0, 0, 0);
        tbl[12] = mk(7, 7, 0, 7, 0, 0, 0,           'h72, 0, 'h72, 0, 0, 0);
        tbl[13] = mk(9, 0, 0, 0, 1, 9, 'h55,        BYP ? 'h55 : 9, 0, 0, 0, 0, 0);
        tbl[14] = mk(9, 0, 0, 0, 0, 0, 0,           'h55, 0, 0, 0, 0, 1);
        tbl[15] = mk(9, 0, 0, 0, 0, 0, 0,           'h55, 0, 0, 0, 0, 0);
        tbl[16] = mk(4, 0, 1, 4, 0, 0, 0,           4, 0, 0, 0, 0, 0);
        tbl[17] = mk(4, 0, 1, 4, 1, 4, 'h44,        BYP ? 'h44 : 4, !BYP, 0, 0, 0, 0);
        tbl[18] = mk(4, 0, 0, 4, 0, 0, 0,           'h44, 1, 0, 0, 0, 0);
        tbl[19] = mk(4, 0, 0, 4, 1, 4, 'h45,        BYP ? 'h45 : 'h44, !BYP, 0, 0, 0, 0);
        tbl[20] = mk(4, 0, 0, 4, 0, 0, 0,           'h45, 0, 0, 0, 0, 0);
        tbl[21] = mk(2, 2, 0, 0, 1, 2, 'h1234,      BYP ? 'h1234 : 2, 0, BYP ? 'h1234 : 2, 0, 0, 0);
        tbl[22] = mk(2, 15, 0, 0, 1, 15, 'hF0,      'h1234, 0, BYP ? 'hF0 : 0, 0, 0, 1);
        tbl[23] = mk(15, 0, 0, 0, 0, 0, 0,          'hF0, 0, 0, 0, 0, 1);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 24; k++) run(tbl[k].i, tbl[k].e);
        chk("dbg_data", dbg_data, 32'hF0);

        // Asynchronous reset mid-operation drops pending counts and the in-flight writeback.
        ri = tbl[0].i; ri.a1 = 6; ri.ie = 1; ri.id = 6;
        re = tbl[0].e; re.d1 = 6; re.d2 = 'h1234; re.b2 = 0; re.err = 0;
        ri.a2 = 2;
        run(ri, re);
        chk("busy_before_rst", 32'(rd_busy1), 32'd1);
        issue_en = 1'b0; rd_addr1 = 2; rd_addr2 = 6; wb_en = 1'b1; wb_dest = 6; wb_data = 'hBAD;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_data", rd_data1, 32'd2);
        chk("async_rst_busy", 32'(rd_busy2), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        chk("rst_wb_dropped", rd_data2, 32'd6);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        @(posedge clk); #1;

        for (int r = 0; r < 16; r++) begin
            m_reg[r] = (r == 15) ? 32'd0 : 32'(r);
            m_cnt[r] = 0;
        end
        m_err = 1'b0;
        for (int n = 0; n < 300; n++) begin
            ri.a1 = 4'($urandom_range(0, 4)); ri.a2 = 4'($urandom_range(0, 4));
            ri.ie = 1'($urandom_range(0, 1)); ri.id = 4'($urandom_range(0, 3));
            ri.we = 1'($urandom_range(0, 1)); ri.wd = 4'($urandom_range(0, 3));
            ri.wdat = $urandom;
            full = m_cnt[ri.id] == 3;
            hit1 = BYP && ri.we && ri.wd == ri.a1;
            hit2 = BYP && ri.we && ri.wd == ri.a2;
            re.d1 = hit1 ? ri.wdat : m_reg[ri.a1];
            re.d2 = hit2 ? ri.wdat : m_reg[ri.a2];
            re.b1 = hit1 ? m_cnt[ri.a1] > 1 : m_cnt[ri.a1] != 0;
            re.b2 = hit2 ? m_cnt[ri.a2] > 1 : m_cnt[ri.a2] != 0;
            re.full = full;
            re.err = m_err;
            run(ri, re);
            m_err = ri.we && m_cnt[ri.wd] == 0;
            if (ri.we && m_cnt[ri.wd] != 0) m_cnt[ri.wd]--;
            if (ri.ie && !full) m_cnt[ri.id]++;
            if (ri.we) m_reg[ri.wd] = ri.wdat;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
